// File: rtl/hw_regs_reader_pkg.sv
// Shared helpers for the hardware register window: read-side lane ordering
// and address-window decode. The register-bank writer imports the same
// functions so both sides agree on byte placement and window membership.
package hw_regs_reader_pkg;

    localparam int MAX_ADDR_BITS = 32;

    // Byte offset within a line for a given output lane: the lowest
    // address sits in the most-significant lane.
    function automatic int lane_off(input int lane, input int nbytes);
        return lane ^ (nbytes - 1);
    endfunction

    // True when addr and base agree on every bit above the window size,
    // looking only at the low addr_bits of the port address space.
    function automatic logic win_hit(input logic [MAX_ADDR_BITS-1:0] addr,
                                     input logic [MAX_ADDR_BITS-1:0] base,
                                     input int addr_bits, input int win_bits);
        logic [MAX_ADDR_BITS-1:0] diff;
        diff = (addr ^ base) >> win_bits;
        for (int k = 0; k < MAX_ADDR_BITS; k++)
            if (k >= addr_bits - win_bits) diff[k] = 1'b0;
        return diff == '0;
    endfunction

endpackage

// File: rtl/hw_regs_reader_if.sv
// Read request / response handshake between a consumer and hw_regs_reader.
interface hw_regs_reader_if #(
    parameter int PORT_ADDR_SIZE  = 19,
    parameter int PORT_CACHE_BITS = 128
);
    logic                       RD_REQ;
    logic                       RD_READY;
    logic [PORT_ADDR_SIZE-1:0]  ADDR_IN;
    logic                       RD_VALID;
    logic                       RD_ACK;
    logic [PORT_CACHE_BITS-1:0] DATA_OUT;
    logic                       RD_HIT;

    modport master (output RD_REQ, ADDR_IN, RD_ACK,
                    input  RD_READY, RD_VALID, DATA_OUT, RD_HIT);
    modport slave  (input  RD_REQ, ADDR_IN, RD_ACK,
                    output RD_READY, RD_VALID, DATA_OUT, RD_HIT);
endinterface

// File: rtl/hw_regs_resp_fifo.sv
// In-order response queue. Pointers carry one extra bit so full and empty
// are distinguishable; the head is read straight out of the storage
// registers and forced to zero when the queue is empty.
module hw_regs_resp_fifo #(
    parameter int WIDTH = 129,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic                     vld_o,
    output logic [WIDTH-1:0]         head_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW:0]      wr_ptr_q, rd_ptr_q;

    // Storage write; contents need no reset since the pointers gate visibility.
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q[PW-1:0]] <= push_data_i;
    end

    // Pointer advance on push/pop; reset empties the queue immediately.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    assign count_o = wr_ptr_q - rd_ptr_q;
    assign vld_o   = (count_o != '0);
    assign head_o  = vld_o ? mem_q[rd_ptr_q[PW-1:0]] : '0;

endmodule

// File: rtl/hw_regs_reader.sv
// Line-wide reader for the live hardware register window. Stage 1 latches
// the line base and window hit; stage 2 gathers the register bytes one
// cycle later and pushes them into the response queue (latency 2).
module hw_regs_reader import hw_regs_reader_pkg::*; #(
    parameter int          PORT_ADDR_SIZE    = 19,
    parameter int          PORT_CACHE_BITS   = 128,
    parameter int          HW_REGS_SIZE      = 14,
    parameter logic [31:0] BASE_READ_ADDRESS = 32'h0,
    parameter int          FIFO_DEPTH        = 4
) (
    input  logic                                CLK,
    input  logic                                RESET_n,
    input  logic [2**HW_REGS_SIZE-1:0][7:0]     HW_REGS__8bit,
    hw_regs_reader_if.slave                     bus
);
    localparam int N  = PORT_CACHE_BITS / 8;
    localparam int LB = $clog2(N);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int W  = PORT_CACHE_BITS + 1;

    logic                    s1_vld_q, s1_hit_q, rdy_en_q;
    logic [HW_REGS_SIZE-1:0] s1_base_q;
    logic                    accept, pop, fifo_vld;
    logic [PW:0]             fifo_cnt;
    logic [PW+1:0]           in_use;
    logic [W-1:0]            push_data, head;

    // Slots already committed: queued responses plus the one in stage 1.
    assign in_use       = (PW+2)'(fifo_cnt) + (PW+2)'(s1_vld_q);
    assign bus.RD_READY = rdy_en_q && (in_use < (PW+2)'(FIFO_DEPTH));
    assign accept       = bus.RD_REQ && bus.RD_READY;
    assign pop          = fifo_vld && bus.RD_ACK;

    // Stage 1: capture line base and window hit of the accepted request.
    // rdy_en_q holds RD_READY low throughout reset and for no longer.
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            rdy_en_q  <= 1'b0;
            s1_vld_q  <= 1'b0;
            s1_hit_q  <= 1'b0;
            s1_base_q <= '0;
        end else begin
            rdy_en_q <= 1'b1;
            s1_vld_q <= accept;
            if (accept) begin
                s1_hit_q  <= win_hit(32'(bus.ADDR_IN), BASE_READ_ADDRESS,
                                     PORT_ADDR_SIZE, HW_REGS_SIZE);
                s1_base_q <= {bus.ADDR_IN[HW_REGS_SIZE-1:LB], LB'(0)};
            end
        end
    end

    // Stage 2: gather the live register bytes into the line; misses read zero.
    always_comb begin
        push_data      = '0;
        push_data[W-1] = s1_hit_q;
        if (s1_hit_q)
            for (int i = 0; i < N; i++)
                push_data[i*8 +: 8] =
                    HW_REGS__8bit[s1_base_q | HW_REGS_SIZE'(lane_off(i, N))];
    end

    hw_regs_resp_fifo #(.WIDTH(W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i       (CLK),
        .rst_n_i     (RESET_n),
        .push_i      (s1_vld_q),
        .push_data_i (push_data),
        .pop_i       (pop),
        .vld_o       (fifo_vld),
        .head_o      (head),
        .count_o     (fifo_cnt)
    );

    assign bus.RD_VALID = fifo_vld;
    assign bus.RD_HIT   = head[W-1];
    assign bus.DATA_OUT = head[W-2:0];

endmodule

// File: tb/tb_hw_regs_reader.sv
// Randomized and directed checks of hw_regs_reader against a queue-based
// reference model: accepted reads produce lines from the register image
// one cycle after acceptance, delivered in order with latency 2.
module tb_hw_regs_reader;
    localparam int          AW   = 19;
    localparam int          CB   = 128;
    localparam int          RS   = 14;
    localparam int          FD   = 4;
    localparam logic [31:0] BASE = 32'h0;

    logic CLK = 1'b0;
    logic RESET_n = 1'b1;
    logic [2**RS-1:0][7:0] regs;

    hw_regs_reader_if #(.PORT_ADDR_SIZE(AW), .PORT_CACHE_BITS(CB)) bus ();

    hw_regs_reader #(
        .PORT_ADDR_SIZE(AW), .PORT_CACHE_BITS(CB), .HW_REGS_SIZE(RS),
        .BASE_READ_ADDRESS(BASE), .FIFO_DEPTH(FD)
    ) dut (
        .CLK(CLK), .RESET_n(RESET_n), .HW_REGS__8bit(regs), .bus(bus)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [CB:0]   expq [$];
    logic          pend = 1'b0;
    logic [AW-1:0] pend_addr = '0;
    logic          rdy_m = 1'b0;

    // Expected line for an address from the current register image:
    // byte at line base + k goes to lane 15-k.
    function automatic logic [CB:0] exp_line(input logic [AW-1:0] a);
        logic [CB:0]   r;
        logic [31:0]   bv;
        logic [RS-1:0] lb;
        r  = '0;
        bv = BASE;
        if (a[AW-1:RS] == bv[AW-1:RS]) begin
            r[CB] = 1'b1;
            lb = {a[RS-1:4], 4'h0};
            for (int k = 0; k < 16; k++) r[(15-k)*8 +: 8] = regs[lb + RS'(k)];
        end
        return r;
    endfunction

    function automatic logic model_ready();
        return rdy_m && ((expq.size() + int'(pend)) < FD);
    endfunction

    // Model step at each rising edge; reset empties everything at once.
    initial begin : model
        logic acc;
        forever begin
            @(posedge CLK or negedge RESET_n);
            if (!RESET_n) begin
                expq.delete();
                pend  = 1'b0;
                rdy_m = 1'b0;
            end else begin
                acc = bus.RD_REQ && model_ready();
                if (expq.size() > 0 && bus.RD_ACK) void'(expq.pop_front());
                if (pend) expq.push_back(exp_line(pend_addr));
                pend      = acc;
                pend_addr = bus.ADDR_IN;
                rdy_m     = 1'b1;
            end
        end
    end

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic test_reset();
        RESET_n = 1'b0;
        repeat (3) tick();
        n_tests++; if (bus.RD_VALID !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", bus.RD_VALID); end
        n_tests++; if (bus.RD_READY !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b exp 0", bus.RD_READY); end
        n_tests++; if (bus.RD_HIT !== 1'b0) begin n_fail++; $display("FAIL reset_hit got %b exp 0", bus.RD_HIT); end
        n_tests++; if (bus.DATA_OUT !== '0) begin n_fail++; $display("FAIL reset_data got %h exp 0", bus.DATA_OUT); end
        RESET_n = 1'b1;
        tick();
        n_tests++; if (bus.RD_READY !== 1'b1) begin n_fail++; $display("FAIL ready_after_reset got %b exp 1", bus.RD_READY); end
    endtask

    task automatic test_basic_hit();
        for (int k = 0; k < 16; k++) regs[16 + k] = 8'(k);
        bus.RD_ACK = 1'b1; bus.RD_REQ = 1'b1; bus.ADDR_IN = 19'h13;
        tick();
        bus.RD_REQ = 1'b0;
        n_tests++; if (bus.RD_VALID !== 1'b0) begin n_fail++; $display("FAIL hit_early_valid got %b exp 0", bus.RD_VALID); end
        tick();
        n_tests++; if (bus.RD_VALID !== 1'b1) begin n_fail++; $display("FAIL hit_valid got %b exp 1", bus.RD_VALID); end
        n_tests++; if (bus.RD_HIT !== 1'b1) begin n_fail++; $display("FAIL hit_flag got %b exp 1", bus.RD_HIT); end
        n_tests++; if (bus.DATA_OUT !== 128'h000102030405060708090A0B0C0D0E0F) begin
            n_fail++; $display("FAIL hit_data got %h exp 000102030405060708090a0b0c0d0e0f", bus.DATA_OUT); end
        tick();
        n_tests++; if (bus.RD_VALID !== 1'b0) begin n_fail++; $display("FAIL hit_popped got %b exp 0", bus.RD_VALID); end
    endtask

    task automatic test_miss();
        bus.RD_ACK = 1'b1; bus.RD_REQ = 1'b1; bus.ADDR_IN = 19'h4_0000;
        tick();
        bus.RD_REQ = 1'b0;
        n_tests++; if (bus.RD_VALID !== 1'b0) begin n_fail++; $display("FAIL miss_early_valid got %b exp 0", bus.RD_VALID); end
        tick();
        n_tests++; if (bus.RD_VALID !== 1'b1) begin n_fail++; $display("FAIL miss_valid got %b exp 1", bus.RD_VALID); end
        n_tests++; if (bus.RD_HIT !== 1'b0) begin n_fail++; $display("FAIL miss_hit got %b exp 0", bus.RD_HIT); end
        n_tests++; if (bus.DATA_OUT !== '0) begin n_fail++; $display("FAIL miss_data got %h exp 0", bus.DATA_OUT); end
        tick();
    endtask

    task automatic test_backpressure();
        int acc_cnt = 0;
        logic [CB:0] e;
        bus.RD_ACK = 1'b0;
        for (int c = 0; c < 6; c++) begin
            bus.RD_REQ  = 1'b1;
            bus.ADDR_IN = {5'b0, 14'($urandom)};
            if (bus.RD_READY === 1'b1) acc_cnt++;
            tick();
        end
        bus.RD_REQ = 1'b0;
        tick();
        n_tests++; if (acc_cnt != 4) begin n_fail++; $display("FAIL bp_accepted got %0d exp 4", acc_cnt); end
        n_tests++; if (bus.RD_READY !== 1'b0) begin n_fail++; $display("FAIL bp_ready_low got %b exp 0", bus.RD_READY); end
        bus.RD_ACK = 1'b1;
        for (int c = 0; c < 4; c++) begin
            e = (expq.size() > 0) ? expq[0] : '0;
            n_tests++; if (bus.RD_VALID !== 1'b1) begin n_fail++; $display("FAIL bp_drain_valid[%0d] got %b exp 1", c, bus.RD_VALID); end
            n_tests++; if ({bus.RD_HIT, bus.DATA_OUT} !== e) begin
                n_fail++; $display("FAIL bp_drain_data[%0d] got %h exp %h", c, {bus.RD_HIT, bus.DATA_OUT}, e); end
            tick();
        end
        n_tests++; if (bus.RD_VALID !== 1'b0) begin n_fail++; $display("FAIL bp_empty got %b exp 0", bus.RD_VALID); end
        n_tests++; if (bus.RD_READY !== 1'b1) begin n_fail++; $display("FAIL bp_ready_high got %b exp 1", bus.RD_READY); end
    endtask

    task automatic test_stream();
        int got = 0;
        logic [CB:0] e;
        bus.RD_ACK = 1'b1;
        for (int c = 0; c < 14; c++) begin
            n_tests++; if (bus.RD_VALID !== (c >= 2)) begin
                n_fail++; $display("FAIL stream_valid[%0d] got %b exp %b", c, bus.RD_VALID, c >= 2); end
            if (bus.RD_VALID === 1'b1) begin
                got++;
                e = (expq.size() > 0) ? expq[0] : '0;
                n_tests++; if ({bus.RD_HIT, bus.DATA_OUT} !== e) begin
                    n_fail++; $display("FAIL stream_data[%0d] got %h exp %h", c, {bus.RD_HIT, bus.DATA_OUT}, e); end
            end
            bus.RD_REQ  = (c < 12);
            bus.ADDR_IN = 19'(c * 16);
            tick();
        end
        bus.RD_REQ = 1'b0;
        n_tests++; if (got != 12) begin n_fail++; $display("FAIL stream_count got %0d exp 12", got); end
        n_tests++; if (bus.RD_VALID !== 1'b0) begin n_fail++; $display("FAIL stream_drained got %b exp 0", bus.RD_VALID); end
    endtask

    task automatic test_write_timing();
        bus.RD_ACK = 1'b1;
        regs[16'h21] = 8'h11;
        bus.RD_REQ = 1'b1; bus.ADDR_IN = 19'h20;
        tick();
        bus.RD_REQ = 1'b0; regs[16'h21] = 8'hAA;
        tick();
        n_tests++; if (bus.DATA_OUT[14*8 +: 8] !== 8'hAA) begin
            n_fail++; $display("FAIL write_t1 got %h exp aa", bus.DATA_OUT[14*8 +: 8]); end
        regs[16'h21] = 8'h11;
        tick();
        bus.RD_REQ = 1'b1; bus.ADDR_IN = 19'h20;
        tick();
        bus.RD_REQ = 1'b0;
        tick();
        regs[16'h21] = 8'hAA;
        n_tests++; if (bus.DATA_OUT[14*8 +: 8] !== 8'h11) begin
            n_fail++; $display("FAIL write_t2 got %h exp 11", bus.DATA_OUT[14*8 +: 8]); end
        tick();
    endtask

    task automatic test_random();
        logic [CB:0] e;
        for (int c = 0; c < 400; c++) begin
            n_tests++; if (bus.RD_VALID !== (expq.size() > 0)) begin
                n_fail++; $display("FAIL rnd_valid[%0d] got %b exp %b", c, bus.RD_VALID, expq.size() > 0); end
            n_tests++; if (bus.RD_READY !== model_ready()) begin
                n_fail++; $display("FAIL rnd_ready[%0d] got %b exp %b", c, bus.RD_READY, model_ready()); end
            if (expq.size() > 0) begin
                e = expq[0];
                n_tests++; if ({bus.RD_HIT, bus.DATA_OUT} !== e) begin
                    n_fail++; $display("FAIL rnd_data[%0d] got %h exp %h", c, {bus.RD_HIT, bus.DATA_OUT}, e); end
            end
            bus.RD_REQ  = ($urandom_range(2, 0) != 0);
            bus.RD_ACK  = $urandom_range(1, 0) == 1;
            bus.ADDR_IN = ($urandom_range(7, 0) == 0) ? 19'($urandom) : {11'b0, 8'($urandom)};
            if ($urandom_range(1, 0) == 1) regs[$urandom_range(255, 0)] = 8'($urandom);
            tick();
        end
        bus.RD_REQ = 1'b0; bus.RD_ACK = 1'b1;
        repeat (6) tick();
    endtask

    task automatic test_reset_mid();
        bus.RD_ACK = 1'b0;
        for (int c = 0; c < 3; c++) begin
            bus.RD_REQ = 1'b1; bus.ADDR_IN = 19'(c * 16);
            tick();
        end
        bus.RD_REQ = 1'b0;
        repeat (2) tick();
        n_tests++; if (bus.RD_VALID !== 1'b1) begin n_fail++; $display("FAIL rstmid_queued got %b exp 1", bus.RD_VALID); end
        RESET_n = 1'b0;
        #1;
        n_tests++; if (bus.RD_VALID !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid got %b exp 0", bus.RD_VALID); end
        n_tests++; if (bus.RD_READY !== 1'b0) begin n_fail++; $display("FAIL rstmid_ready got %b exp 0", bus.RD_READY); end
        repeat (2) tick();
        RESET_n = 1'b1; bus.RD_ACK = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            n_tests++; if (bus.RD_VALID !== 1'b0) begin n_fail++; $display("FAIL rstmid_stale[%0d] got %b exp 0", c, bus.RD_VALID); end
        end
        bus.RD_REQ = 1'b1; bus.ADDR_IN = 19'h13;
        tick();
        bus.RD_REQ = 1'b0;
        tick();
        n_tests++; if (bus.RD_VALID !== 1'b1) begin n_fail++; $display("FAIL rstmid_new got %b exp 1", bus.RD_VALID); end
        n_tests++; if ({bus.RD_HIT, bus.DATA_OUT} !== exp_line(19'h13)) begin
            n_fail++; $display("FAIL rstmid_new_data got %h exp %h", {bus.RD_HIT, bus.DATA_OUT}, exp_line(19'h13)); end
        tick();
    endtask

    initial begin
        bus.RD_REQ = 1'b0; bus.RD_ACK = 1'b0; bus.ADDR_IN = '0;
        for (int k = 0; k < 2**RS; k++) regs[k] = 8'($urandom);
        #1;
        test_reset();
        test_basic_hit();
        test_miss();
        test_backpressure();
        test_stream();
        test_write_timing();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hw_regs_reader.md
HW_REGS_READER -- requirements
Module: hw_regs_reader

Interface
REQ-001 SHALL have parameter PORT_ADDR_SIZE, default 19: request address width.
REQ-002 SHALL have parameter PORT_CACHE_BITS, default 128: read line width; bytes per line N = PORT_CACHE_BITS/8.
REQ-003 SHALL have parameter HW_REGS_SIZE, default 14: register window is 2^HW_REGS_SIZE bytes.
REQ-004 SHALL have parameter BASE_READ_ADDRESS, default 32'h0: window base in the port address space.
REQ-005 SHALL have parameter FIFO_DEPTH, default 4 (power of 2, >=2): response queue entries.
REQ-006 CLK  input  1  sole clock; all state on rising edge.
REQ-007 RESET_n  input  1  asynchronous, active-low reset.
REQ-008 RD_REQ  input  1  read request strobe.
REQ-009 RD_READY  output  1  request may be accepted this cycle.
REQ-010 ADDR_IN  input  PORT_ADDR_SIZE  request byte address.
REQ-011 HW_REGS__8bit  input  8 x 2^HW_REGS_SIZE  live register byte array from the register bank.
REQ-012 RD_VALID  output  1  response at queue head valid.
REQ-013 RD_ACK  input  1  consumer takes head response.
REQ-014 DATA_OUT  output  PORT_CACHE_BITS  response line data.
REQ-015 RD_HIT  output  1  response address was inside the window.

Function
REQ-016 Request accepted in cycle T iff RD_REQ && RD_READY; otherwise ignored, no state change.
REQ-017 Hit = ADDR_IN[PORT_ADDR_SIZE-1:HW_REGS_SIZE] == BASE_READ_ADDRESS[PORT_ADDR_SIZE-1:HW_REGS_SIZE].
REQ-018 Line base = ADDR_IN[HW_REGS_SIZE-1:0] with low log2(N) bits cleared.
REQ-019 Byte lane i of DATA_OUT (bits i*8+:8) = HW_REGS__8bit[base | (i ^ (N-1))], i.e. lowest address in the most-significant lane.
REQ-020 Miss: DATA_OUT all zero, RD_HIT=0; hit: RD_HIT=1.
REQ-021 Pipeline: stage 1 registers base/hit at edge ending T; stage 2 samples register bytes and pushes to queue at edge ending T+1.
REQ-022 Data reflects register contents present during cycle T+1.
REQ-023 Empty queue: RD_VALID rises in cycle T+2 (latency 2).
REQ-024 Responses leave in request order; head pops at edge where RD_VALID && RD_ACK.
REQ-025 RD_ACK while RD_VALID=0 SHALL be ignored.
REQ-026 Head outputs (DATA_OUT, RD_HIT) SHALL stay stable while RD_VALID && !RD_ACK.
REQ-027 RD_READY = (queue occupancy + in-flight stage-1/stage-2 entries) < FIFO_DEPTH; never overflow.
REQ-028 Simultaneous push and pop SHALL keep occupancy unchanged; back-to-back acceptance with RD_ACK held high sustains one response per cycle.
REQ-029 Queue pointers wrap modulo FIFO_DEPTH with separate full/empty distinction (extra pointer bit or counter).

Reset
REQ-030 RESET_n low SHALL immediately clear pipeline valids, queue pointers and occupancy.
REQ-031 During reset: RD_VALID=0, RD_READY=0, RD_HIT=0, DATA_OUT=0.
REQ-032 Reset mid-operation discards all queued and in-flight requests; no stale response after release.
REQ-033 RD_READY SHALL return high on the first clock edge after RESET_n deasserts.

Structure
REQ-034 Shared package SHALL hold the lane-swizzle function (lane index to byte offset) and the window-hit function, also used by the register-bank writer.
REQ-035 Response queue SHALL be sub-module hw_regs_resp_fifo (width PORT_CACHE_BITS+1, depth FIFO_DEPTH, registered head output).

Verification
REQ-036 Regs[0x10..0x1F]=0x00..0x0F, read 0x13, RD_ACK=1 -> cycle T+2 RD_VALID=1, RD_HIT=1, DATA_OUT=128'h000102030405060708090A0B0C0D0E0F.
REQ-037 BASE_READ_ADDRESS=0, read 0x4_0000 -> RD_HIT=0, DATA_OUT=0, latency 2.
REQ-038 RD_ACK=0, issue 6 requests -> exactly 4 accepted, RD_READY low afterward; then RD_ACK=1 -> 4 responses in order, RD_READY high again.
REQ-039 Streaming reads 0x00,0x10,0x20,... with RD_ACK=1 -> one response per cycle, no drops, correct order.
REQ-040 Write 0xAA to reg 0x21 during cycle T+1 of read 0x20 -> lane 14 = 0xAA; written during T+2 -> old value.
REQ-041 Assert RESET_n low with 3 responses queued -> RD_VALID=0 at once; after release no response until a new request.
